// File: rtl/cpu_bus_unit_if.sv
// Request and bus-side signal bundle for cpu_bus_unit.
// Latency: none; pure wiring.
// Backpressure: the bus throttles beats through i_bus_data_ready; the core sees o_busy.
//
// Ports (signals carried):
//   request side : i_req, i_we, i_size, i_sext, i_addr, i_wdata
//   result side  : o_busy, o_done, o_err, o_rdata
//   bus side     : o_bus_clk, o_bus_we, o_bus_addr, o_bus_data, i_bus_data, i_bus_data_ready
// The slave modport is the unit's view; the master modport is the view of
// whoever drives requests and models the bus.
interface cpu_bus_unit_if #(
  parameter int ADDR_W = 32,
  parameter int REG_W  = 32,
  parameter int BUS_W  = 8
);
  logic              i_req;
  logic              i_we;
  logic [1:0]        i_size;
  logic              i_sext;
  logic [ADDR_W-1:0] i_addr;
  logic [REG_W-1:0]  i_wdata;
  logic              o_busy;
  logic              o_done;
  logic              o_err;
  logic [REG_W-1:0]  o_rdata;
  logic              o_bus_clk;
  logic              o_bus_we;
  logic [ADDR_W-1:0] o_bus_addr;
  logic [BUS_W-1:0]  o_bus_data;
  logic [BUS_W-1:0]  i_bus_data;
  logic              i_bus_data_ready;

  modport slave (
    input  i_req, i_we, i_size, i_sext, i_addr, i_wdata, i_bus_data, i_bus_data_ready,
    output o_busy, o_done, o_err, o_rdata, o_bus_clk, o_bus_we, o_bus_addr, o_bus_data
  );

  modport master (
    output i_req, i_we, i_size, i_sext, i_addr, i_wdata, i_bus_data, i_bus_data_ready,
    input  o_busy, o_done, o_err, o_rdata, o_bus_clk, o_bus_we, o_bus_addr, o_bus_data
  );
endinterface

// File: rtl/cpu_bus_unit.sv
// Splits one 1/2/4/8-byte load/store into little-endian BUS_W-bit strobed beats.
// Latency: o_done 2*beats+1 cycles after acceptance with no wait states.
// Backpressure: each beat waits on i_bus_data_ready (aborts after TIMEOUT); requests ignored while busy.
//
// Ports:
//   i_clk : clock, rising edge
//   i_rst : asynchronous reset, active low
//   bus   : cpu_bus_unit_if.slave (request, result and external bus signals)
module cpu_bus_unit #(
  parameter int ADDR_W  = 32,
  parameter int REG_W   = 32,
  parameter int BUS_W   = 8,
  parameter int TIMEOUT = 255
) (
  input logic           i_clk,
  input logic           i_rst,
  cpu_bus_unit_if.slave bus
);

  localparam int BB    = BUS_W / 8;
  localparam int BB_LG = $clog2(BB);
  localparam int RB_LG = $clog2(REG_W / 8);
  localparam int WT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [REG_W-1:0] LANE_MASK = REG_W'({BUS_W{1'b1}});

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;

  state_t            state_q, state_d;
  logic              we_q, sext_q, err_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [REG_W-1:0]  wdata_q, res_q, rdata_q;
  logic [3:0]        k_q;
  logic [WT_W-1:0]   wait_q;

  logic              accept, oversize, last_beat, timed_out;
  int                beats_m1, nbits, lane_sh;
  logic [REG_W-1:0]  res_d, ext, wr_shift;
  logic              sbit;

  assign accept    = (state_q == IDLE) && bus.i_req;
  assign oversize  = int'(bus.i_size) > RB_LG;
  // Accesses no wider than the bus take a single beat on the low lanes.
  assign beats_m1  = (int'(size_q) > BB_LG) ? ((1 << (int'(size_q) - BB_LG)) - 1) : 0;
  assign last_beat = int'(k_q) == beats_m1;
  assign timed_out = (TIMEOUT != 0) && ((int'(wait_q) + 1) == TIMEOUT);
  assign lane_sh   = int'(k_q) * BUS_W;
  assign nbits     = 8 << size_q;
  assign wr_shift  = wdata_q >> lane_sh;

  // Merge the current beat into the result so the last beat can be extended
  // in the same cycle it arrives.
  always_comb begin
    res_d = (res_q & ~(LANE_MASK << lane_sh)) | (REG_W'(bus.i_bus_data) << lane_sh);
    sbit  = 1'b0;
    for (int i = 0; i < REG_W; i++) begin
      if (i == nbits - 1) sbit = res_d[i];
    end
    ext = '0;
    for (int i = 0; i < REG_W; i++) begin
      ext[i] = (i < nbits) ? res_d[i] : (sext_q & sbit);
    end
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.i_req) state_d = oversize ? DONE : SETUP;
      SETUP:   state_d = STROBE;
      STROBE: begin
        if (bus.i_bus_data_ready) state_d = last_beat ? DONE : SETUP;
        else if (timed_out)       state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode from state, so reset clears the strobe without a clock edge.
  always_comb begin
    bus.o_busy     = state_q != IDLE;
    bus.o_done     = state_q == DONE;
    bus.o_err      = (state_q == DONE) && err_q;
    bus.o_bus_clk  = state_q == STROBE;
    bus.o_bus_we   = ((state_q == SETUP) || (state_q == STROBE)) && we_q;
    bus.o_bus_addr = addr_q + (ADDR_W'(k_q) << BB_LG);
    bus.o_bus_data = wr_shift[BUS_W-1:0];
    bus.o_rdata    = rdata_q;
  end

  // Request latch, beat/wait counters and result capture
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      we_q    <= 1'b0;
      sext_q  <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      res_q   <= '0;
      rdata_q <= '0;
      k_q     <= '0;
      wait_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept && oversize) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end else if (accept) begin
            we_q    <= bus.i_we;
            sext_q  <= bus.i_sext;
            size_q  <= bus.i_size;
            addr_q  <= bus.i_addr;
            wdata_q <= bus.i_wdata;
            err_q   <= 1'b0;
            res_q   <= '0;
            k_q     <= '0;
          end
        end
        SETUP: wait_q <= '0;
        STROBE: begin
          if (bus.i_bus_data_ready) begin
            if (!we_q) res_q <= res_d;
            if (last_beat) begin
              if (!we_q) rdata_q <= ext;
            end else begin
              k_q <= k_q + 4'd1;
            end
          end else begin
            wait_q <= wait_q + WT_W'(1);
            if (timed_out) begin
              err_q   <= 1'b1;
              res_q   <= '0;
              rdata_q <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_bus_unit.sv
module tb_cpu_bus_unit;
  logic i_clk = 1'b0;
  logic i_rst = 1'b0;
  always #5 i_clk = ~i_clk;

  cpu_bus_unit_if #(.ADDR_W(32), .REG_W(32), .BUS_W(8))  if8 ();
  cpu_bus_unit_if #(.ADDR_W(32), .REG_W(32), .BUS_W(32)) if32 ();

  cpu_bus_unit #(.ADDR_W(32), .REG_W(32), .BUS_W(8), .TIMEOUT(8)) u_dut8 (
    .i_clk(i_clk), .i_rst(i_rst), .bus(if8)
  );
  cpu_bus_unit #(.ADDR_W(32), .REG_W(32), .BUS_W(32), .TIMEOUT(8)) u_dut32 (
    .i_clk(i_clk), .i_rst(i_rst), .bus(if32)
  );

  // Byte memory behind the 8-bit bus, indexed by the low address nibble.
  logic [7:0] mem [16];
  assign if8.i_bus_data = mem[if8.o_bus_addr[3:0]];

  int total = 0;
  int bad   = 0;

  int          lat, nstrobe, nbeats, we_bad, extra_done;
  logic        done_seen, d_err, d_bclk;
  logic [31:0] d_rdata;
  logic [31:0] baddr [8];
  logic [7:0]  bdata [8];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Issue one request on the 8-bit unit and follow it to o_done.
  // hold_lo: number of STROBE cycles with ready low before ready rises.
  // pulse_at: cycle (after acceptance) at which i_req is pulsed again; 0 = never.
  task automatic xfer8(input logic we, input logic [1:0] size, input logic sext,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input int hold_lo, input int pulse_at);
    @(negedge i_clk);
    if8.i_req = 1'b1; if8.i_we = we; if8.i_size = size; if8.i_sext = sext;
    if8.i_addr = addr; if8.i_wdata = wdata;
    if8.i_bus_data_ready = (hold_lo == 0);
    lat = 0; nstrobe = 0; nbeats = 0; we_bad = 0; done_seen = 1'b0;
    @(posedge i_clk);
    while (!done_seen && lat < 40) begin
      @(negedge i_clk);
      lat++;
      if8.i_req = (lat == pulse_at);
      if (if8.o_bus_clk) begin
        nstrobe++;
        if8.i_bus_data_ready = (nstrobe > hold_lo);
        if (if8.o_bus_we !== we) we_bad++;
        if (if8.i_bus_data_ready && nbeats < 8) begin
          baddr[nbeats] = if8.o_bus_addr;
          bdata[nbeats] = if8.o_bus_data;
          nbeats++;
        end
      end
      if (if8.o_done) begin
        done_seen = 1'b1;
        d_err     = if8.o_err;
        d_rdata   = if8.o_rdata;
        d_bclk    = if8.o_bus_clk;
      end
    end
    if8.i_req = 1'b0;
    if8.i_bus_data_ready = 1'b0;
    chk("done_seen8", done_seen, 1'b1);
  endtask

  task automatic xfer32(input logic [1:0] size, input logic sext, input logic [31:0] addr);
    @(negedge i_clk);
    if32.i_req = 1'b1; if32.i_we = 1'b0; if32.i_size = size; if32.i_sext = sext;
    if32.i_addr = addr;
    lat = 0; nstrobe = 0; done_seen = 1'b0;
    @(posedge i_clk);
    while (!done_seen && lat < 40) begin
      @(negedge i_clk);
      lat++;
      if32.i_req = 1'b0;
      if (if32.o_bus_clk) nstrobe++;
      if (if32.o_done) begin
        done_seen = 1'b1;
        d_err     = if32.o_err;
        d_rdata   = if32.o_rdata;
      end
    end
    chk("done_seen32", done_seen, 1'b1);
  endtask

  initial begin
    if8.i_req = 0; if8.i_we = 0; if8.i_size = 0; if8.i_sext = 0;
    if8.i_addr = '0; if8.i_wdata = '0; if8.i_bus_data_ready = 0;
    if32.i_req = 0; if32.i_we = 0; if32.i_size = 0; if32.i_sext = 0;
    if32.i_addr = '0; if32.i_wdata = '0; if32.i_bus_data_ready = 1'b1;
    if32.i_bus_data = 32'h5A5A5A80;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[14] = 8'h11; mem[15] = 8'h22; mem[0] = 8'h33; mem[1] = 8'h44;
    mem[5]  = 8'h80; mem[6]  = 8'h00; mem[7] = 8'h90;

    // Reset state
    #12;
    chk("rst_ctl", {if8.o_busy, if8.o_done, if8.o_err, if8.o_bus_clk, if8.o_bus_we}, 5'b0);
    chk("rst_addr", if8.o_bus_addr, 32'h0);
    chk("rst_data", if8.o_bus_data, 8'h0);
    chk("rst_rdata", if8.o_rdata, 32'h0);
    @(negedge i_clk);
    i_rst = 1'b1;

    // 4-byte load crossing 0x2000
    xfer8(1'b0, 2'd2, 1'b0, 32'h00001FFE, 32'h0, 0, 0);
    chk("ld4_beats", nbeats, 4);
    chk("ld4_a0", baddr[0], 32'h00001FFE);
    chk("ld4_a1", baddr[1], 32'h00001FFF);
    chk("ld4_a2", baddr[2], 32'h00002000);
    chk("ld4_a3", baddr[3], 32'h00002001);
    chk("ld4_rdata", d_rdata, 32'h44332211);
    chk("ld4_lat", lat, 9);
    chk("ld4_err", d_err, 1'b0);

    // 2-byte store wrapping the address space
    xfer8(1'b1, 2'd1, 1'b0, 32'hFFFFFFFF, 32'h0000BEEF, 0, 0);
    chk("st2_beats", nbeats, 2);
    chk("st2_a0", baddr[0], 32'hFFFFFFFF);
    chk("st2_d0", bdata[0], 8'hEF);
    chk("st2_a1", baddr[1], 32'h00000000);
    chk("st2_d1", bdata[1], 8'hBE);
    chk("st2_we", we_bad, 0);
    chk("st2_lat", lat, 5);
    chk("st2_rdata_kept", d_rdata, 32'h44332211);

    // Byte loads with sign/zero extension
    xfer8(1'b0, 2'd0, 1'b1, 32'h00000005, 32'h0, 0, 0);
    chk("ldb_sext", d_rdata, 32'hFFFFFF80);
    chk("ldb_lat", lat, 3);
    xfer8(1'b0, 2'd0, 1'b0, 32'h00000005, 32'h0, 0, 0);
    chk("ldb_zext", d_rdata, 32'h00000080);

    // Wide bus: narrow and full-width loads take one beat
    xfer32(2'd0, 1'b1, 32'h00000100);
    chk("w32b_rdata", d_rdata, 32'hFFFFFF80);
    chk("w32b_strobes", nstrobe, 1);
    chk("w32b_lat", lat, 3);
    xfer32(2'd2, 1'b1, 32'h00000100);
    chk("w32w_rdata", d_rdata, 32'h5A5A5A80);
    chk("w32w_strobes", nstrobe, 1);

    // Three wait states
    xfer8(1'b0, 2'd0, 1'b0, 32'h00000005, 32'h0, 3, 0);
    chk("ws_strobes", nstrobe, 4);
    chk("ws_lat", lat, 6);
    chk("ws_rdata", d_rdata, 32'h00000080);

    // Timeout abort, ready never asserted
    xfer8(1'b0, 2'd2, 1'b0, 32'h00000000, 32'h0, 1000, 0);
    chk("to_strobes", nstrobe, 8);
    chk("to_lat", lat, 10);
    chk("to_err", d_err, 1'b1);
    chk("to_rdata", d_rdata, 32'h0);
    chk("to_bclk", d_bclk, 1'b0);

    // Halfword sign extension, then an oversize request clears the result
    xfer8(1'b0, 2'd1, 1'b1, 32'h00000006, 32'h0, 0, 0);
    chk("ldh_sext", d_rdata, 32'hFFFF9000);
    xfer8(1'b0, 2'd3, 1'b0, 32'h00000000, 32'h0, 0, 0);
    chk("ovs_lat", lat, 1);
    chk("ovs_err", d_err, 1'b1);
    chk("ovs_strobes", nstrobe, 0);
    chk("ovs_rdata", d_rdata, 32'h0);

    // Request pulsed while busy is ignored
    xfer8(1'b0, 2'd1, 1'b0, 32'h00001FFE, 32'h0, 0, 2);
    chk("pulse_rdata", d_rdata, 32'h00002211);
    chk("pulse_lat", lat, 5);
    extra_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      if (if8.o_done) extra_done++;
    end
    chk("pulse_extra_done", extra_done, 0);
    chk("pulse_idle", if8.o_busy, 1'b0);

    // Asynchronous reset in the middle of a strobe
    @(negedge i_clk);
    if8.i_req = 1'b1; if8.i_we = 1'b0; if8.i_size = 2'd2; if8.i_sext = 1'b0;
    if8.i_addr = 32'h00000010; if8.i_bus_data_ready = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    if8.i_req = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    chk("pre_rst_bclk", if8.o_bus_clk, 1'b1);
    #2 i_rst = 1'b0;
    #1;
    chk("arst_ctl", {if8.o_busy, if8.o_done, if8.o_bus_clk}, 3'b0);
    chk("arst_addr", if8.o_bus_addr, 32'h0);
    @(negedge i_clk);
    i_rst = 1'b1;
    xfer8(1'b0, 2'd0, 1'b1, 32'h00000005, 32'h0, 0, 0);
    chk("post_rst_lat", lat, 3);
    chk("post_rst_rdata", d_rdata, 32'hFFFFFF80);
    chk("post_rst_err", d_err, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop if the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got stalled expected finished");
    $fatal(1);
  end
endmodule

// File: doc/cpu_bus_unit.md
Name: cpu_bus_unit

Overview:
Parametrised bus interface unit between the CPU core's execution sequencer and the external memory/IO bus. It turns one 1/2/4/8-byte load or store request into a sequence of strobed bus beats of BUS_W bits each, in little-endian order. It supports wait states, a timeout abort, and sign/zero extension of loads. It replaces the single-width, core-embedded bus strobe logic and lets 65832 wide register operations run over a narrow bus.

Parameters:
ADDR_W, 32, address width in bits; byte addressing.
REG_W, 32, widest transfer and o_rdata width in bits; must be 8, 16, 32 or 64.
BUS_W, 8, bus data width in bits; must be 8, 16 or 32, and must be ≤ REG_W.
TIMEOUT, 255, maximum STROBE cycles waiting for ready before abort; 0 disables the timeout.

Ports:
i_clk  in  1  clock; all state changes on the rising edge
i_rst  in  1  reset; asynchronous assertion, active-low (0 = reset)
i_req  in  1  request valid; sampled only in IDLE
i_we  in  1  1 = store, 0 = load
i_size  in  2  transfer bytes = 1 << i_size
i_sext  in  1  load only: 1 = sign-extend to REG_W, 0 = zero-extend
i_addr  in  ADDR_W  start byte address
i_wdata  in  REG_W  store data; low bytes used
o_busy  out  1  high from the cycle after acceptance through the DONE cycle
o_done  out  1  one-cycle completion pulse
o_err  out  1  high only together with o_done, when the transfer failed
o_rdata  out  REG_W  load result; valid when o_done=1, held until the next acceptance
o_bus_clk  out  1  bus strobe
o_bus_we  out  1  bus write enable
o_bus_addr  out  ADDR_W  bus beat address
o_bus_data  out  BUS_W  bus write data
i_bus_data  in  BUS_W  bus read data
i_bus_data_ready  in  1  beat completion from the bus

Behaviour:
- Reset (i_rst=0), asynchronous:
  - all outputs are 0; state is IDLE; internal counters and data registers are cleared;
  - an in-flight transfer is abandoned with no o_done.
- Derived values:
  - nbytes = 1 << i_size; BB = BUS_W/8;
  - beats = ceil(nbytes/BB), with a minimum of 1;
  - a narrow access on a wide bus uses one beat and only the low lanes.
- IDLE:
  - i_req=1 with nbytes > REG_W/8: go to DONE with o_err=1, no bus activity;
  - otherwise latch we/size/sext/addr/wdata, set beat counter k=0, go to SETUP;
  - i_req=0: stay in IDLE.
- SETUP (1 cycle):
  - o_bus_addr = latched addr + k*BB, wrapping modulo 2^ADDR_W;
  - o_bus_we = we; o_bus_data = wdata bytes [k*BB .. k*BB+BB-1];
  - o_bus_clk=0; go to STROBE.
- STROBE:
  - o_bus_clk=1; address, we and data stay stable;
  - i_bus_data_ready=1: a load stores i_bus_data into result lanes k*BB..; o_bus_clk drops next cycle; if k = beats-1 go to DONE, else k++ and go to SETUP;
  - ready=0: increment the wait counter; when it equals TIMEOUT (TIMEOUT≠0) go to DONE with err=1 and discard the partial load data.
- DONE (1 cycle):
  - o_done=1; o_err as determined above;
  - a successful load drives o_rdata = extended result;
  - an error drives o_rdata = 0; a store leaves o_rdata unchanged;
  - o_bus_clk=0, o_bus_we=0; go to IDLE.
- Extension: the result is truncated to nbytes; the top bit of byte nbytes-1 is replicated when sext=1, otherwise the upper bits are zero-filled.
- Latency with ready always high: o_done is asserted 2*beats+1 cycles after the acceptance edge.
- i_req while not in IDLE is ignored; there is no queuing. A request held high through DONE is accepted in the following IDLE cycle.
- The wait counter clears at every SETUP.

Test Plan:
- REG_W=32, BUS_W=8, ready tied high. Load size=2 at 0x00001FFE over memory bytes 11 22 33 44 -> beat addresses 1FFE,1FFF,2000,2001; o_rdata=0x44332211; o_done 9 cycles after acceptance; o_err=0.
- Store size=1 (2 bytes), wdata 0x0000BEEF at 0xFFFFFFFF -> beat0 addr FFFFFFFF data EF, beat1 addr 00000000 data BE; o_bus_we=1 during both strobes; o_done after 5 cycles.
- Load size=0 reading byte 0x80 -> o_rdata=0xFFFFFF80 with sext=1, 0x00000080 with sext=0. Same load with BUS_W=32 -> exactly one beat, low lane used.
- Ready low for 3 STROBE cycles on a 1-byte load -> o_bus_clk high for 4 cycles; o_done 6 cycles after acceptance. With TIMEOUT=8 and ready never asserted -> o_done=o_err=1 after 8 STROBE cycles; o_rdata=0; o_bus_clk low in DONE.
- i_size=3 with REG_W=32 -> o_done=o_err=1 on the cycle after acceptance; o_bus_clk never rises. i_req pulsed while busy -> ignored; exactly one o_done.
- Drive i_rst=0 mid-STROBE of a 4-byte load -> o_bus_clk, o_busy and o_done fall to 0 without waiting for a clock edge. After release, a new 1-byte load completes normally in 3 cycles.
